// File: rtl/load_store_unit.sv
// RV32I load/store stage: aligns stores onto byte lanes, drives a valid/ready
// data-memory bus, extracts and extends load data, and reports access errors.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        stall,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        misaligned,
    output logic        bus_err
);

    // state  | meaning
    // IDLE   | waiting for a request; stall follows a legal accept
    // REQ    | mem_req held until mem_ready or timeout
    // DONE   | one-cycle completion: done plus writeback or error pulse
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    rd_q, rd_d;
    logic [2:0]    f3_q, f3_d;
    logic [1:0]    off_q, off_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]    mem_wstrb_q, mem_wstrb_d;
    logic          wb_en_q, wb_en_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          done_q, done_d;
    logic          misaligned_q, misaligned_d;
    logic          bus_err_q, bus_err_d;

    logic          accept, f3_ok, unaligned, go, bad;
    logic [CW-1:0] cnt_inc;
    logic          timeout_hit;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic [31:0]   load_v;

    always_comb begin
        accept = start & (is_load ^ is_store);
        f3_ok  = 1'b0;
        if (is_load) begin
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
        end else begin
            f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        end
        unaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        go  = accept & f3_ok & ~unaligned;
        bad = (start & is_load & is_store) | (accept & ~go);
    end

    assign cnt_inc     = cnt_q + CW'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

    always_comb begin
        byte_v = mem_rdata[{off_q, 3'b000} +: 8];
        half_v = mem_rdata[{off_q[1], 4'b0000} +: 16];
        case (f3_q)
            3'b000:  load_v = {{24{byte_v[7]}}, byte_v};
            3'b100:  load_v = {24'd0, byte_v};
            3'b001:  load_v = {{16{half_v[15]}}, half_v};
            3'b101:  load_v = {16'd0, half_v};
            default: load_v = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        f3_d         = f3_q;
        off_d        = off_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        wb_en_d      = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        done_d       = 1'b0;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (go) begin
                    state_d    = S_REQ;
                    mem_req_d  = 1'b1;
                    mem_we_d   = is_store;
                    mem_addr_d = {addr[31:2], 2'b00};
                    rd_d       = rd;
                    f3_d       = funct3;
                    off_d      = addr[1:0];
                    if (is_store) begin
                        case (funct3[1:0])
                            2'b00: begin
                                mem_wdata_d = {4{store_data[7:0]}};
                                mem_wstrb_d = 4'b0001 << addr[1:0];
                            end
                            2'b01: begin
                                mem_wdata_d = {2{store_data[15:0]}};
                                mem_wstrb_d = addr[1] ? 4'b1100 : 4'b0011;
                            end
                            default: begin
                                mem_wdata_d = store_data;
                                mem_wstrb_d = 4'b1111;
                            end
                        endcase
                    end else begin
                        mem_wdata_d = '0;
                        mem_wstrb_d = 4'b0000;
                    end
                end else if (bad) begin
                    // errors skip the bus entirely and never stall the core
                    state_d      = S_DONE;
                    done_d       = 1'b1;
                    misaligned_d = 1'b1;
                end
            end
            S_REQ: begin
                if (mem_ready) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (!mem_we_q) begin
                        wb_en_d   = (rd_q != 5'd0);
                        wb_rd_d   = rd_q;
                        wb_data_d = load_v;
                    end
                end else if (timeout_hit) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            rd_q         <= '0;
            f3_q         <= '0;
            off_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            wb_en_q      <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            wb_en_q      <= wb_en_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            done_q       <= done_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // stall is the only combinational output: the PC must hold in the accept cycle
    assign stall = (state_q == S_REQ) | ((state_q == S_IDLE) & go);

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign wb_en      = wb_en_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign done       = done_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle data-memory access stage feeding the register file write port of the RV32I core. Accepts one load/store per request from decode/ALU, performs byte-lane alignment, drives a valid/ready data-memory bus, and stalls the core until complete. Loads return sign/zero-extended data with destination index and a one-cycle write enable; misaligned, illegal and timed-out accesses raise error pulses instead.

Parameters:
TIMEOUT, 16, max cycles mem_req may wait for mem_ready; 0 disables the timeout.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request valid; sampled only in IDLE
is_load  in  1  request is a load
is_store  in  1  request is a store; is_load=is_store=1 treated as illegal
funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  effective byte address (ALU result)
store_data  in  32  rs2 value
rd  in  5  load destination register
mem_req  out  1  bus request, held until handshake
mem_we  out  1  1 = write
mem_addr  out  32  word address, {addr[31:2],2'b00}
mem_wdata  out  32  lane-replicated store data
mem_wstrb  out  4  byte enables, 0000 for reads
mem_ready  in  1  bus accept/complete
mem_rdata  in  32  read data, valid when mem_ready=1 on a read
stall  out  1  freeze PC/pipeline
wb_en  out  1  one-cycle register write enable
wb_rd  out  5  write index
wb_data  out  32  write data
done  out  1  one-cycle completion pulse (success or error)
misaligned  out  1  one-cycle alignment/illegal-funct3 pulse
bus_err  out  1  one-cycle timeout pulse

Behaviour:
- Reset: state IDLE; every output 0; timeout counter 0. Reset mid-access drops mem_req asynchronously, no writeback.
- States: IDLE, REQ, DONE.
- IDLE: accept = start & (is_load ^ is_store). If accepted and legal+aligned: capture mem_addr/mem_we/mem_wdata/mem_wstrb/rd/funct3/addr[1:0], next REQ. stall = accept (combinational) so PC holds.
- Illegal funct3 (load 011/110/111; store anything but 000/001/010), or misaligned (H/HU/SH with addr[0]=1; W with addr[1:0]!=0), or is_load=is_store=1: next cycle misaligned=1 and done=1, no bus access, no writeback; stall stays 0 (the trap path owns the PC). start with neither is_load nor is_store is ignored.
- REQ: mem_req=1, stall=1; bus outputs stable. On mem_ready=1: latch mem_rdata, next DONE. Counter increments each REQ cycle; when it reaches TIMEOUT (TIMEOUT>0) without mem_ready: drop mem_req, next DONE with bus_err.
- DONE (1 cycle): mem_req=0, stall=0, done=1. Load success: wb_en=(rd!=0), wb_rd=rd, wb_data=extracted. Store or error: wb_en=0. Next IDLE; start in DONE is ignored.
- Latency: access with mem_ready on first REQ cycle = done 2 cycles after accept edge.
- Store lanes: SB wdata={4{d[7:0]}}, wstrb=0001<<addr[1:0]; SH wdata={2{d[15:0]}}, wstrb=0011<<(2*addr[1]); SW wdata=d, wstrb=1111.
- Load extraction: byte = rdata[8*a+7:8*a] (a=addr[1:0]); half = rdata[16*addr[1]+15:16*addr[1]]; B/H sign-extend, BU/HU zero-extend, W pass-through.
- All outputs registered except stall.

Test Plan:
- SW addr=0x104, store_data=0xDEADBEEF, mem_ready 1 cycle after mem_req -> mem_addr=0x104, wstrb=1111, wdata=0xDEADBEEF, done 2 cycles after accept, wb_en=0.
- LB addr=0x203, rdata=0x80112233, rd=5 -> wb_en=1, wb_rd=5, wb_data=0xFFFFFF80; LBU same -> 0x00000080; LH addr=0x202 -> 0xFFFF8011; LHU -> 0x00008011.
- SB addr=0x11 data=0x000000AB -> mem_addr=0x10, wstrb=0010, wdata=0xABABABAB; SH addr=0x12 -> wstrb=1100.
- LW addr=0x102 -> misaligned=1, done=1 next cycle, mem_req never asserted, wb_en=0; LW rd=0 aligned -> done=1, wb_en=0.
- TIMEOUT=4, mem_ready held 0 -> mem_req high exactly 4 cycles, then bus_err=1, done=1, wb_en=0, stall drops.
- rst asserted while mem_req=1 with mem_ready=0 -> mem_req, stall, wb_en 0 immediately; subsequent LW completes normally.
